// File: rtl/regfile_sb_multiport_pkg.sv
// Core-wide register file types and sizing helpers shared by decode, writeback
// and the register file itself.
package rv_rf_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    // Index width for a register count; never narrower than one bit.
    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    typedef logic [XLEN_DEFAULT-1:0]         rf_data_t;
    typedef logic [$clog2(NREG_DEFAULT)-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_sb_multiport_if.sv
// Decode/writeback view of the register file: write port, issue port,
// packed read ports and the registered busy/pending status.
interface regfile_sb_multiport_if
    import rv_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2
);
    localparam int AW = addr_width(NREG);

    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                pend_any;

    modport master (
        output we, waddr, wdata, raddr, iss_valid, iss_rd,
        input  rdata, rd_busy, pend_any
    );

    modport slave (
        input  we, waddr, wdata, raddr, iss_valid, iss_rd,
        output rdata, rd_busy, pend_any
    );

endinterface

// File: rtl/regfile_sb_multiport_scoreboard.sv
// In-flight write scoreboard: one pending bit per register, set on issue and
// cleared on writeback, with the next-state vector exported for bypassed reads.
module rf_scoreboard
    import rv_rf_pkg::*;
#(
    parameter int NREG     = NREG_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [NREG-1:0] pending_next,
    output logic            pend_any
);

    logic [NREG-1:0] pending;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pending_next = pending;
        if (we) begin
            pending_next[waddr] = 1'b0;
        end
        if (iss_valid) begin
            pending_next[iss_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_any <= 1'b0;
        end else begin
            pending  <= pending_next;
            pend_any <= |pending_next;
        end
    end

endmodule

// File: rtl/regfile_sb_multiport.sv
// Multi-port integer register file with registered reads, write-to-read bypass,
// optional hardwired x0 and an in-flight write scoreboard for RAW stalls.
module regfile_sb_multiport
    import rv_rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREG     = NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_sb_multiport_if.slave  bus
);

    localparam int AW = addr_width(NREG);

    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     pending_next;
    logic                pend_any;
    logic                write_ok;
    logic [XLEN-1:0]     rd_next [NRD];
    logic [NRD-1:0]      busy_next;
    logic [NRD*XLEN-1:0] rdata_q;
    logic [NRD-1:0]      busy_q;

    assign write_ok = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));

    rf_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .we           (bus.we),
        .waddr        (bus.waddr),
        .iss_valid    (bus.iss_valid),
        .iss_rd       (bus.iss_rd),
        .pending_next (pending_next),
        .pend_any     (pend_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (write_ok) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Each port sees the register as it will be after this edge's write.
    always_comb begin
        logic [AW-1:0] ra;
        ra = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.raddr[k*AW +: AW];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_next[k] = '0;
            end else if (bus.we && (bus.waddr == ra)) begin
                rd_next[k] = bus.wdata;
            end else begin
                rd_next[k] = regs[ra];
            end
            busy_next[k] = pending_next[ra];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                rdata_q[k*XLEN +: XLEN] <= rd_next[k];
            end
            busy_q <= busy_next;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_busy  = busy_q;
    assign bus.pend_any = pend_any;

endmodule

// File: tb/tb_regfile_sb_multiport.sv
// Scoreboard bench: directed vectors on the default configuration, then a
// 4-port/16-reg/64-bit instance with x0 ordinary swept against a reference model.
module tb_regfile_sb_multiport;

    typedef struct {
        string       name;
        logic [4:0]  chk;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        b0;
        logic        b1;
        logic        pa;
    } exp_a_t;

    typedef struct {
        int           cyc;
        logic [255:0] rd;
        logic [3:0]   busy;
        logic         pa;
    } exp_b_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;

    exp_a_t q_a [$];
    exp_b_t q_b [$];

    logic [63:0] mregs [16];
    logic [15:0] mpend;

    regfile_sb_multiport_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_a ();
    regfile_sb_multiport_if #(.XLEN(64), .NREG(16), .NRD(4)) bus_b ();

    regfile_sb_multiport #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    regfile_sb_multiport #(.XLEN(64), .NREG(16), .NRD(4), .ZERO_REG(0)) dut_wide (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // chk bits: [0] rdata0 [1] rdata1 [2] rd_busy0 [3] rd_busy1 [4] pend_any
    task automatic applyStimulus(input string name, input logic r, input logic w, input int wa,
                                 input logic [31:0] wd, input int ra0, input int ra1,
                                 input logic iv, input int ird, input logic [4:0] chk,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic eb0, input logic eb1, input logic epa);
        exp_a_t e;
        @(negedge clk);
        rst_a           = r;
        bus_a.we        = w;
        bus_a.waddr     = 5'(wa);
        bus_a.wdata     = wd;
        bus_a.raddr     = {5'(ra1), 5'(ra0)};
        bus_a.iss_valid = iv;
        bus_a.iss_rd    = 5'(ird);
        e.name = name;
        e.chk  = chk;
        e.rd0  = e0;
        e.rd1  = e1;
        e.b0   = eb0;
        e.b1   = eb1;
        e.pa   = epa;
        q_a.push_back(e);
    endtask

    // Reference: apply the write, then the scoreboard update, then read.
    task automatic sweepCycle(input int cyc, input logic w, input int wa, input logic [63:0] wd,
                              input logic [15:0] ra, input logic iv, input int ird);
        exp_b_t e;
        @(negedge clk);
        bus_b.we        = w;
        bus_b.waddr     = 4'(wa);
        bus_b.wdata     = wd;
        bus_b.raddr     = ra;
        bus_b.iss_valid = iv;
        bus_b.iss_rd    = 4'(ird);
        if (w) begin
            mregs[wa] = wd;
            mpend[wa] = 1'b0;
        end
        if (iv) begin
            mpend[ird] = 1'b1;
        end
        e.cyc = cyc;
        e.rd  = '0;
        for (int k = 0; k < 4; k++) begin
            e.rd[k*64 +: 64] = mregs[ra[k*4 +: 4]];
            e.busy[k]        = mpend[ra[k*4 +: 4]];
        end
        e.pa = |mpend;
        q_b.push_back(e);
    endtask

    initial begin
        exp_a_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                if (e.chk[0]) checkOutput({e.name, ".rdata0"}, 256'(bus_a.rdata[31:0]), 256'(e.rd0));
                if (e.chk[1]) checkOutput({e.name, ".rdata1"}, 256'(bus_a.rdata[63:32]), 256'(e.rd1));
                if (e.chk[2]) checkOutput({e.name, ".rd_busy0"}, 256'(bus_a.rd_busy[0]), 256'(e.b0));
                if (e.chk[3]) checkOutput({e.name, ".rd_busy1"}, 256'(bus_a.rd_busy[1]), 256'(e.b1));
                if (e.chk[4]) checkOutput({e.name, ".pend_any"}, 256'(bus_a.pend_any), 256'(e.pa));
            end
        end
    end

    initial begin
        exp_b_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checkOutput($sformatf("sweep%0d.rdata", e.cyc), bus_b.rdata, e.rd);
                checkOutput($sformatf("sweep%0d.rd_busy", e.cyc), 256'(bus_b.rd_busy), 256'(e.busy));
                checkOutput($sformatf("sweep%0d.pend_any", e.cyc), 256'(bus_b.pend_any), 256'(e.pa));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0;
        bus_a.raddr = '0; bus_a.iss_valid = 1'b0; bus_a.iss_rd = '0;
        bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0;
        bus_b.raddr = '0; bus_b.iss_valid = 1'b0; bus_b.iss_rd = '0;
        for (int r = 0; r < 16; r++) mregs[r] = '0;
        mpend = '0;

        //            name          rst we wa  wdata          ra0 ra1 iv ird chk     rd0            rd1            b0 b1 pa
        applyStimulus("reset",      1, 0, 0,  32'h0,         0,  0,  0, 0,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("wr5",        0, 1, 5,  32'hDEAD_BEEF, 0,  0,  0, 0,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("rd5",        0, 0, 0,  32'h0,         5,  7,  0, 0,  5'h1F, 32'hDEAD_BEEF, 32'h0,         0, 0, 0);
        applyStimulus("bypass7",    0, 1, 7,  32'h1234,      7,  7,  0, 0,  5'h1F, 32'h1234,      32'h1234,      0, 0, 0);
        applyStimulus("rd7_5",      0, 0, 0,  32'h0,         7,  5,  0, 0,  5'h1F, 32'h1234,      32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus("x0_wr_iss",  0, 1, 0,  32'hFFFF_FFFF, 0,  5,  1, 0,  5'h1F, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus("x0_rd",      0, 0, 0,  32'h0,         0,  0,  0, 0,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("iss3",       0, 0, 0,  32'h0,         3,  5,  1, 3,  5'h1F, 32'h0,         32'hDEAD_BEEF, 1, 0, 1);
        applyStimulus("hold3",      0, 0, 0,  32'h0,         3,  7,  0, 0,  5'h1F, 32'h0,         32'h1234,      1, 0, 1);
        applyStimulus("wr_iss3",    0, 1, 3,  32'hAAAA_5555, 3,  7,  1, 3,  5'h1F, 32'hAAAA_5555, 32'h1234,      1, 0, 1);
        applyStimulus("retire3",    0, 1, 3,  32'h0000_1111, 3,  7,  0, 0,  5'h1F, 32'h0000_1111, 32'h1234,      0, 0, 0);
        applyStimulus("iss9_wr12",  0, 1, 12, 32'hCAFE,      9,  12, 1, 9,  5'h1F, 32'h0,         32'hCAFE,      1, 0, 1);
        applyStimulus("retire9",    0, 1, 9,  32'h99,        9,  3,  0, 0,  5'h1F, 32'h99,        32'h0000_1111, 0, 0, 0);
        applyStimulus("iss20",      0, 0, 0,  32'h0,         20, 12, 1, 20, 5'h1F, 32'h0,         32'hCAFE,      1, 0, 1);
        applyStimulus("midreset",   1, 1, 5,  32'h77,        5,  6,  1, 6,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("post_rst",   0, 0, 0,  32'h0,         5,  20, 0, 0,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("post_rst7",  0, 0, 0,  32'h0,         7,  12, 0, 0,  5'h1F, 32'h0,         32'h0,         0, 0, 0);
        applyStimulus("idle",       0, 0, 0,  32'h0,         0,  0,  0, 0,  5'h00, 32'h0,         32'h0,         0, 0, 0);

        @(negedge clk);
        rst_b = 1'b0;
        sweepCycle(0, 1'b1, 0, 64'hFFFF_FFFF, 16'h0000, 1'b1, 0);
        sweepCycle(1, 1'b0, 0, 64'h0, 16'h0000, 1'b0, 0);
        for (int i = 2; i < 10000; i++) begin
            sweepCycle(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       {$urandom, $urandom}, 16'($urandom),
                       1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        bus_b.we        = 1'b0;
        bus_b.iss_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("drain_a", 256'(q_a.size()), 256'(0));
        checkOutput("drain_b", 256'(q_b.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
